// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle MIPS core front end:
// next-PC select encoding, trap return registers and reset/trap vectors.
// The vector constants are also consumed by the ROM image generator.
package cpu_pkg;

    // Next-PC source selected by the decoder
    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2,
        PC_JR     = 2'd3
    } pc_sel_t;

    // Trap return-address registers ($k0 for interrupts, $k1 for exceptions)
    localparam logic [4:0] REG_XP     = 5'd26;
    localparam logic [4:0] REG_XP_EXC = 5'd27;

    // ROM words 0, 1 and 2 hold the reset, interrupt and exception entries
    localparam logic [31:0] VEC_RESET = 32'h8000_0000;
    localparam logic [31:0] VEC_IRQ   = 32'h8000_0004;
    localparam logic [31:0] VEC_EXC   = 32'h8000_0008;

    localparam int unsigned ROM_WORDS_DEFAULT = 150;

    // Branch displacement in bytes, sign-extended to the 31-bit address field
    function automatic logic [30:0] branch_offset(input logic [15:0] imm);
        return {{13{imm[15]}}, imm, 2'b00};
    endfunction

    // Sequential successor: bits 30:0 wrap, the kernel bit is carried through
    function automatic logic [31:0] seq_addr(input logic [31:0] pc);
        return {pc[31], pc[30:0] + 31'd4};
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Synchroniser for the asynchronous interrupt line followed by a
// rising-edge detector on the synchronised level. Fewer than two stages
// are never built, whatever SYNC_STAGES says.
module irq_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    localparam int unsigned STAGES_C = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES_C-1:0] sync_r;
    logic                prev_r;

    // Shift the raw request through the metastability chain and remember
    // the previous synchronised level for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[STAGES_C-2:0], async_in};
            prev_r <= sync_r[STAGES_C-1];
        end
    end

    assign rise = sync_r[STAGES_C-1] & ~prev_r;

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: holds the PC (bit 31 = kernel mode), selects the
// next PC, latches synchronised interrupt edges and raises the trap write of
// the return address. ROM access has zero latency, so everything except the
// PC and the pending flag is combinational.
// Optional build macro FETCH_BOUND_CHECK_EN: user-mode fetches beyond the ROM
// depth are turned into illegal-op exceptions.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VEC   = VEC_RESET,
    parameter logic [31:0] IRQ_VEC     = VEC_IRQ,
    parameter logic [31:0] EXC_VEC     = VEC_EXC,
    parameter int unsigned ROM_WORDS   = ROM_WORDS_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic [1:0]  pc_sel_i,
    input  logic        branch_taken_i,
    input  logic [15:0] imm16_i,
    input  logic [25:0] jtarget_i,
    input  logic [31:0] jr_target_i,
    input  logic        illop_i,
    input  logic        irq_i,
    output logic [31:0] pc_o,
    output logic [30:0] rom_addr_o,
    output logic [31:0] pc_plus4_o,
    output logic        kernel_o,
    output logic        squash_o,
    output logic        trap_we_o,
    output logic [4:0]  trap_reg_o,
    output logic [31:0] trap_data_o,
    output logic        irq_ack_o
);

`ifdef FETCH_BOUND_CHECK_EN
    localparam bit BOUND_EN_C = 1'b1;
`else
    localparam bit BOUND_EN_C = 1'b0;
`endif

    localparam logic [28:0] ROM_LIMIT_C = 29'(ROM_WORDS);

    logic [31:0] pc_r;
    logic        pending_r;

    logic [31:0] pc_next_s;
    logic        pending_next_s;
    logic [31:0] pc_plus4_s;
    logic [31:0] branch_tgt_s;
    logic [31:0] jump_tgt_s;
    logic [31:0] sel_tgt_s;
    logic        kernel_s;
    logic        bound_fault_s;
    logic        exc_take_s;
    logic        irq_take_s;
    logic        irq_rise_s;

    irq_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_irq_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (irq_i),
        .rise     (irq_rise_s)
    );

    assign kernel_s = pc_r[31];

    // Candidate addresses; branch arithmetic wraps inside bits 30:0
    always_comb begin
        pc_plus4_s   = seq_addr(pc_r);
        branch_tgt_s = {pc_plus4_s[31], pc_plus4_s[30:0] + branch_offset(imm16_i)};
        jump_tgt_s   = {pc_plus4_s[31:28], jtarget_i, 2'b00};
    end

    // Decoder-requested successor; spare encodings fall back to sequential
    always_comb begin
        sel_tgt_s = pc_plus4_s;
        case (pc_sel_t'(pc_sel_i))
            PC_SEQ:    sel_tgt_s = pc_plus4_s;
            PC_BRANCH: begin
                if (branch_taken_i) begin
                    sel_tgt_s = branch_tgt_s;
                end else begin
                    sel_tgt_s = pc_plus4_s;
                end
            end
            PC_JUMP:   sel_tgt_s = jump_tgt_s;
            PC_JR:     sel_tgt_s = jr_target_i;
            default:   sel_tgt_s = pc_plus4_s;
        endcase
    end

    // Trap qualification: kernel mode and stalls mask both trap kinds,
    // an exception in the same cycle defers the interrupt
    always_comb begin
        bound_fault_s = BOUND_EN_C && !kernel_s && (pc_r[30:2] >= ROM_LIMIT_C);
        exc_take_s    = !stall_i && !kernel_s && (illop_i || bound_fault_s);
        irq_take_s    = !stall_i && !kernel_s && pending_r && !illop_i && !bound_fault_s;
    end

    // Next PC, pending update and trap side effects in priority order
    always_comb begin
        pc_next_s      = sel_tgt_s;
        pending_next_s = pending_r | irq_rise_s;
        squash_o       = 1'b0;
        trap_we_o      = 1'b0;
        trap_reg_o     = 5'd0;
        trap_data_o    = 32'd0;
        irq_ack_o      = 1'b0;
        if (stall_i) begin
            pc_next_s = pc_r;
        end else if (exc_take_s) begin
            pc_next_s   = EXC_VEC;
            squash_o    = 1'b1;
            trap_we_o   = 1'b1;
            trap_reg_o  = REG_XP_EXC;
            trap_data_o = pc_plus4_s;
        end else if (irq_take_s) begin
            // Return to the interrupted instruction; an edge arriving in
            // this very cycle stays pending for the next opportunity
            pc_next_s      = IRQ_VEC;
            pending_next_s = irq_rise_s;
            squash_o       = 1'b1;
            trap_we_o      = 1'b1;
            trap_reg_o     = REG_XP;
            trap_data_o    = pc_r;
            irq_ack_o      = 1'b1;
        end else begin
            pc_next_s = sel_tgt_s;
        end
    end

    // Architectural PC and latched interrupt request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r      <= RESET_VEC;
            pending_r <= 1'b0;
        end else begin
            pc_r      <= pc_next_s;
            pending_r <= pending_next_s;
        end
    end

    assign pc_o       = pc_r;
    assign rom_addr_o = pc_r[30:0];
    assign pc_plus4_o = pc_plus4_s;
    assign kernel_o   = pc_r[31];

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed vector table, hand-written
// interrupt/exception sequences and randomized traffic against a reference
// model. Honours FETCH_BOUND_CHECK_EN the same way the design does.
module tb_pc_fetch_unit;

    localparam int          SYNC = 2;
    localparam int          ROMW = 150;
    localparam logic [31:0] RV   = 32'h8000_0000;
    localparam logic [31:0] IV   = 32'h8000_0004;
    localparam logic [31:0] EV   = 32'h8000_0008;
`ifdef FETCH_BOUND_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic [1:0]  pc_sel_i;
    logic        branch_taken_i;
    logic [15:0] imm16_i;
    logic [25:0] jtarget_i;
    logic [31:0] jr_target_i;
    logic        illop_i;
    logic        irq_i;
    logic [31:0] pc_o;
    logic [30:0] rom_addr_o;
    logic [31:0] pc_plus4_o;
    logic        kernel_o;
    logic        squash_o;
    logic        trap_we_o;
    logic [4:0]  trap_reg_o;
    logic [31:0] trap_data_o;
    logic        irq_ack_o;

    pc_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_i        (stall_i),
        .pc_sel_i       (pc_sel_i),
        .branch_taken_i (branch_taken_i),
        .imm16_i        (imm16_i),
        .jtarget_i      (jtarget_i),
        .jr_target_i    (jr_target_i),
        .illop_i        (illop_i),
        .irq_i          (irq_i),
        .pc_o           (pc_o),
        .rom_addr_o     (rom_addr_o),
        .pc_plus4_o     (pc_plus4_o),
        .kernel_o       (kernel_o),
        .squash_o       (squash_o),
        .trap_we_o      (trap_we_o),
        .trap_reg_o     (trap_reg_o),
        .trap_data_o    (trap_data_o),
        .irq_ack_o      (irq_ack_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_pc;
    bit          m_pending;
    bit          hist[$];      // irq_i as sampled at each clock edge, newest first
    logic [31:0] e_p4, e_next;
    bit          e_exc, e_irq;

    task automatic model_reset();
        m_pc      = RV;
        m_pending = 1'b0;
        hist.delete();
        for (int i = 0; i <= SYNC; i++) hist.push_back(1'b0);
    endtask

    task automatic model_eval();
        bit          kern;
        bit          bound;
        int          off_i;
        logic [31:0] raw;
        kern  = m_pc[31];
        e_p4  = {m_pc[31], m_pc[30:0] + 31'd4};
        bound = BC && !kern && (int'(m_pc[30:2]) >= ROMW);
        e_exc = !stall_i && !kern && (illop_i || bound);
        e_irq = !stall_i && !kern && m_pending && !e_exc;
        if (stall_i) e_next = m_pc;
        else if (e_exc) e_next = EV;
        else if (e_irq) e_next = IV;
        else begin
            case (pc_sel_i)
                2'd1: begin
                    if (branch_taken_i) begin
                        off_i  = $signed(imm16_i) * 4;
                        raw    = e_p4 + 32'(off_i);
                        e_next = {e_p4[31], raw[30:0]};
                    end else e_next = e_p4;
                end
                2'd2:    e_next = {e_p4[31:28], jtarget_i, 2'b00};
                2'd3:    e_next = jr_target_i;
                default: e_next = e_p4;
            endcase
        end
    endtask

    task automatic model_check();
        chk ("pc",        pc_o, m_pc);
        chk ("rom_addr",  {1'b0, rom_addr_o}, {1'b0, m_pc[30:0]});
        chk ("pc_plus4",  pc_plus4_o, e_p4);
        chkb("kernel",    kernel_o, m_pc[31]);
        chkb("squash",    squash_o, e_exc || e_irq);
        chkb("trap_we",   trap_we_o, e_exc || e_irq);
        chk ("trap_reg",  32'(trap_reg_o), e_exc ? 32'd27 : (e_irq ? 32'd26 : 32'd0));
        chk ("trap_data", trap_data_o, e_exc ? e_p4 : (e_irq ? m_pc : 32'd0));
        chkb("irq_ack",   irq_ack_o, e_irq);
    endtask

    task automatic model_step();
        bit rise;
        rise      = hist[SYNC-1] && !hist[SYNC];
        m_pending = (m_pending && !e_irq) || rise;
        m_pc      = e_next;
        hist.push_front(irq_i);
        void'(hist.pop_back());
    endtask

    // Drive at posedge+1, check at negedge, then cross the next edge
    task automatic drive(input bit st, input logic [1:0] sel, input bit tk,
                         input logic [15:0] imm, input logic [25:0] jt,
                         input logic [31:0] jr, input bit il, input bit irq);
        stall_i = st; pc_sel_i = sel; branch_taken_i = tk; imm16_i = imm;
        jtarget_i = jt; jr_target_i = jr; illop_i = il; irq_i = irq;
    endtask

    task automatic sample();
        @(negedge clk);
        model_eval();
        model_check();
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic seq_cycle(input logic [1:0] sel, input logic [31:0] jr, input bit irq);
        drive(1'b0, sel, 1'b0, 16'd0, 26'd0, jr, 1'b0, irq);
        sample();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          st;
        logic [1:0]  sel;
        bit          tk;
        logic [15:0] imm;
        logic [25:0] jt;
        logic [31:0] jr;
        bit          il;
        bit          exp_sq;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit st, logic [1:0] sel, bit tk, logic [15:0] imm,
                                logic [25:0] jt, logic [31:0] jr, bit il,
                                bit sq, logic [31:0] pc);
        vec_t v;
        v.st = st; v.sel = sel; v.tk = tk; v.imm = imm; v.jt = jt; v.jr = jr;
        v.il = il; v.exp_sq = sq; v.exp_pc = pc;
        return v;
    endfunction

    initial begin
        int take_at;
        bit found;

        tbl.push_back(mk(0, 2'd0, 0, 16'h0000, 26'h0,  32'h0,         0, 0, 32'h8000_0004));
        tbl.push_back(mk(0, 2'd0, 0, 16'h0000, 26'h0,  32'h0,         0, 0, 32'h8000_0008));
        tbl.push_back(mk(0, 2'd0, 0, 16'h0000, 26'h0,  32'h0,         0, 0, 32'h8000_000C));
        tbl.push_back(mk(0, 2'd3, 0, 16'h0000, 26'h0,  32'h0000_0100, 0, 0, 32'h0000_0100));
        tbl.push_back(mk(0, 2'd1, 1, 16'hFFFD, 26'h0,  32'h0,         0, 0, 32'h0000_00F8));
        tbl.push_back(mk(0, 2'd3, 0, 16'h0000, 26'h0,  32'h0000_0100, 0, 0, 32'h0000_0100));
        tbl.push_back(mk(0, 2'd1, 0, 16'hFFFD, 26'h0,  32'h0,         0, 0, 32'h0000_0104));
        tbl.push_back(mk(0, 2'd2, 0, 16'h0000, 26'h1C, 32'h0,         0, 0, 32'h0000_0070));
        tbl.push_back(mk(0, 2'd3, 0, 16'h0000, 26'h0,  32'h8000_0054, 0, 0, 32'h8000_0054));
        tbl.push_back(mk(0, 2'd2, 0, 16'h0000, 26'h1C, 32'h0,         0, 0, 32'h8000_0070));
        tbl.push_back(mk(0, 2'd0, 0, 16'h0000, 26'h0,  32'h0,         1, 0, 32'h8000_0074));
        tbl.push_back(mk(0, 2'd3, 0, 16'h0000, 26'h0,  32'h0000_000C, 0, 0, 32'h0000_000C));
        tbl.push_back(mk(1, 2'd0, 0, 16'h0000, 26'h0,  32'h0,         0, 0, 32'h0000_000C));
        tbl.push_back(mk(1, 2'd3, 0, 16'h0000, 26'h0,  32'h8000_0000, 1, 0, 32'h0000_000C));
        tbl.push_back(mk(0, 2'd1, 1, 16'h0010, 26'h0,  32'h0,         0, 0, 32'h0000_0050));
        tbl.push_back(mk(0, 2'd3, 0, 16'h0000, 26'h0,  32'h7FFF_FFFC, 0, 0, 32'h7FFF_FFFC));
        tbl.push_back(mk(0, 2'd0, 0, 16'h0000, 26'h0,  32'h0,         0, BC, BC ? EV : 32'h0000_0000));
        tbl.push_back(mk(0, 2'd3, 0, 16'h0000, 26'h0,  32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC));
        tbl.push_back(mk(0, 2'd0, 0, 16'h0000, 26'h0,  32'h0,         0, 0, 32'h8000_0000));
        tbl.push_back(mk(0, 2'd3, 0, 16'h0000, 26'h0,  32'h0000_0258, 0, 0, 32'h0000_0258));
        tbl.push_back(mk(0, 2'd0, 0, 16'h0000, 26'h0,  32'h0,         0, BC, BC ? EV : 32'h0000_025C));
        tbl.push_back(mk(0, 2'd3, 0, 16'h0000, 26'h0,  32'h0000_0000, 0, 0, 32'h0000_0000));
        tbl.push_back(mk(0, 2'd1, 1, 16'hFFFE, 26'h0,  32'h0,         0, 0, 32'h7FFF_FFFC));
        tbl.push_back(mk(0, 2'd3, 0, 16'h0000, 26'h0,  32'h8000_0000, 0, BC, BC ? EV : 32'h8000_0000));

        // ---- reset ----
        rst_n = 1'b0;
        drive(1'b0, 2'd0, 1'b0, 16'd0, 26'd0, 32'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk ("reset_pc",        pc_o, RV);
        chk ("reset_rom_addr",  {1'b0, rom_addr_o}, 32'd0);
        chkb("reset_squash",    squash_o, 1'b0);
        chkb("reset_trap_we",   trap_we_o, 1'b0);
        chk ("reset_trap_reg",  32'(trap_reg_o), 32'd0);
        chk ("reset_trap_data", trap_data_o, 32'd0);
        chkb("reset_irq_ack",   irq_ack_o, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();

        // ---- directed table ----
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].st, tbl[i].sel, tbl[i].tk, tbl[i].imm, tbl[i].jt,
                  tbl[i].jr, tbl[i].il, 1'b0);
            sample();
            chkb($sformatf("tbl%0d_squash", i), squash_o, tbl[i].exp_sq);
            advance();
            chk ($sformatf("tbl%0d_pc", i), pc_o, tbl[i].exp_pc);
            chkb($sformatf("tbl%0d_kernel", i), kernel_o, tbl[i].exp_pc[31]);
        end

        // ---- interrupt taken in user mode ----
        seq_cycle(2'd3, 32'h0000_0080, 1'b0);
        advance();
        chk("irq_user_pc", pc_o, 32'h0000_0080);
        seq_cycle(2'd3, 32'h0000_0080, 1'b1);
        advance();
        found = 1'b0;
        take_at = -1;
        for (int k = 0; k < 8; k++) begin
            seq_cycle(2'd3, 32'h0000_0080, 1'b0);
            if (irq_ack_o) begin
                found = 1'b1;
                take_at = k;
                chk ("irq_trap_reg",  32'(trap_reg_o), 32'd26);
                chk ("irq_trap_data", trap_data_o, 32'h0000_0080);
                chkb("irq_squash",    squash_o, 1'b1);
                advance();
                chk ("irq_vector_pc", pc_o, IV);
                break;
            end
            advance();
        end
        chkb("irq_taken", found, 1'b1);
        chkb("irq_latency_le3", (take_at >= 0) && (take_at <= 3), 1'b1);
        seq_cycle(2'd3, IV, 1'b0);
        chkb("irq_ack_one_cycle", irq_ack_o, 1'b0);
        advance();

        // ---- second pulse held while in kernel mode ----
        seq_cycle(2'd3, IV, 1'b1);
        advance();
        for (int k = 0; k < 6; k++) begin
            seq_cycle(2'd3, IV, 1'b0);
            chkb("irq_held_kernel", irq_ack_o, 1'b0);
            advance();
        end
        seq_cycle(2'd3, 32'h0000_0200, 1'b0);
        chkb("irq_held_jr_cycle", irq_ack_o, 1'b0);
        advance();
        chkb("jr_exit_kernel", kernel_o, 1'b0);
        seq_cycle(2'd0, 32'd0, 1'b0);
        chkb("irq_after_jr_ack",  irq_ack_o, 1'b1);
        chk ("irq_after_jr_data", trap_data_o, 32'h0000_0200);
        chk ("irq_after_jr_reg",  32'(trap_reg_o), 32'd26);
        advance();
        chk("irq_after_jr_pc", pc_o, IV);

        // ---- exception under stall with an interrupt arriving ----
        seq_cycle(2'd3, 32'h0000_0040, 1'b0);
        advance();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 2'd0, 1'b0, 16'd0, 26'd0, 32'd0, 1'b1, (k == 0));
            sample();
            chkb("stall_squash",  squash_o, 1'b0);
            chkb("stall_trap_we", trap_we_o, 1'b0);
            chkb("stall_irq_ack", irq_ack_o, 1'b0);
            advance();
            chk("stall_pc_hold", pc_o, 32'h0000_0040);
        end
        drive(1'b0, 2'd0, 1'b0, 16'd0, 26'd0, 32'd0, 1'b1, 1'b0);
        sample();
        chkb("exc_trap_we",   trap_we_o, 1'b1);
        chk ("exc_trap_reg",  32'(trap_reg_o), 32'd27);
        chk ("exc_trap_data", trap_data_o, 32'h0000_0044);
        chkb("exc_no_irq_ack", irq_ack_o, 1'b0);
        advance();
        chk("exc_vector_pc", pc_o, EV);
        for (int k = 0; k < 2; k++) begin
            seq_cycle(2'd0, 32'd0, 1'b0);
            chkb("exc_handler_no_ack", irq_ack_o, 1'b0);
            advance();
        end
        seq_cycle(2'd3, 32'h0000_0044, 1'b0);
        advance();
        chk("exc_return_pc", pc_o, 32'h0000_0044);
        seq_cycle(2'd0, 32'd0, 1'b0);
        chkb("deferred_irq_ack",  irq_ack_o, 1'b1);
        chk ("deferred_irq_data", trap_data_o, 32'h0000_0044);
        advance();
        chk("deferred_irq_pc", pc_o, IV);

        // ---- randomized traffic against the model ----
        for (int n = 0; n < 400; n++) begin
            logic [31:0] jr;
            logic [15:0] imm;
            imm = 16'($urandom_range(0, 40)) - 16'd20;
            if ($urandom_range(0, 3) == 0) jr = $urandom;
            else jr = {1'($urandom_range(0, 1)), 31'($urandom_range(0, 200) * 4)};
            drive(($urandom_range(0, 9) == 0), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), imm, 26'($urandom), jr,
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0));
            sample();
            advance();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
